// File: rtl/alu_issue_pkg.sv
// Shared constants, decoded-entry payload and helpers for the ALU issue stage.
package alu_issue_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned ILEN   = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] FUNCT7_SUB = 7'h20;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } issue_entry_t;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue-to-ALU operand bus with valid/ready handshake.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] alu_instr;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [XLEN-1:0] out_rs2;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output out_valid, alu_instr, alu_in1, alu_in2, out_rs2, out_pc, out_illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, alu_instr, alu_in1, alu_in2, out_rs2, out_pc, out_illegal,
        output out_ready
    );
endinterface

// File: rtl/alu_issue_imm_gen.sv
// Combinational operand selection, immediate generation and funct3/funct7 rewrite.
module alu_issue_imm_gen
    import alu_issue_pkg::*;
(
    input  logic [ILEN-1:0] instr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] pc,
    output issue_entry_t    entry_c
);

    logic [6:0] opcode;
    logic [2:0] f3;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];

    always_comb begin
        entry_c       = '0;
        entry_c.instr = instr;
        entry_c.rs2   = rs2_val;
        entry_c.pc    = pc;
        case (opcode)
            OP: begin
                entry_c.in1 = rs1_val;
                entry_c.in2 = rs2_val;
            end
            OP_IMM: begin
                entry_c.in1 = rs1_val;
                // Shifts carry shamt[5] in bit 25; clear it so funct7 selects srl/sra.
                if (f3 == F3_SLL || f3 == F3_SR) begin
                    entry_c.in2           = XLEN'(instr[25:20]);
                    entry_c.instr[31:25]  = {instr[31:26], 1'b0};
                    entry_c.illegal       = (f3 == F3_SLL) && (instr[31:26] != 6'd0);
                end else begin
                    entry_c.in2           = sext12(instr[31:20]);
                    entry_c.instr[31:25]  = 7'd0;
                end
            end
            LOAD: begin
                entry_c.in1 = rs1_val;
                entry_c.in2 = sext12(instr[31:20]);
            end
            STORE: begin
                entry_c.in1           = rs1_val;
                entry_c.in2           = sext12({instr[31:25], instr[11:7]});
                entry_c.instr[14:12]  = F3_ADD;
                entry_c.instr[31:25]  = 7'd0;
            end
            BRANCH: begin
                entry_c.in1 = rs1_val;
                entry_c.in2 = rs2_val;
                // Compare ops map onto sub/slt/sltu in the ALU.
                case (f3)
                    F3_BEQ, F3_BNE: begin
                        entry_c.instr[14:12] = F3_ADD;
                        entry_c.instr[31:25] = FUNCT7_SUB;
                    end
                    F3_BLT, F3_BGE:   entry_c.instr[14:12] = F3_SLT;
                    F3_BLTU, F3_BGEU: entry_c.instr[14:12] = F3_SLTU;
                    default:          entry_c.illegal      = 1'b1;
                endcase
            end
            default: entry_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: regfile operand read, decode, and output register with one-entry skid.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    alu_issue_if.master       alu
);

    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    issue_entry_t    out_q, out_d;
    issue_entry_t    skid_q, skid_d;
    issue_entry_t    dec_entry;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            accept;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign rs1_val  = (rs1_addr == '0) ? '0 : rs1_data;
    assign rs2_val  = (rs2_addr == '0) ? '0 : rs2_data;

    alu_issue_imm_gen u_imm_gen (
        .instr   (in_instr),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .pc      (in_pc),
        .entry_c (dec_entry)
    );

    assign accept = in_valid && !skid_valid_q;

    // Output stage refills from skid first so ordering is preserved.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || alu.out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = dec_entry;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = dec_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready        = !skid_valid_q;
    assign alu.out_valid   = out_valid_q;
    assign alu.alu_instr   = out_q.instr;
    assign alu.alu_in1     = out_q.in1;
    assign alu.alu_in2     = out_q.in2;
    assign alu.out_rs2     = out_q.rs2;
    assign alu.out_pc      = out_q.pc;
    assign alu.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed decode table, handshake sequences, randomized scoreboard run.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [63:0] in_pc = 64'd0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data = 64'd0;
    logic [63:0] rs2_data = 64'd0;

    alu_issue_if bus ();

    alu_issue dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .alu      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] in1;
        logic [63:0] in2;
        logic [63:0] rs2;
        logic [63:0] pc;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [31:0] e_instr;
        logic [63:0] e_in1;
        logic [63:0] e_in2;
        logic [63:0] e_rs2;
        logic        e_ill;
    } vec_t;

    vec_t vecs[11];
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".valid"},   64'(bus.out_valid), 64'd1);
        chk({tag, ".instr"},   64'(bus.alu_instr), 64'(e.instr));
        chk({tag, ".in1"},     bus.alu_in1, e.in1);
        chk({tag, ".in2"},     bus.alu_in2, e.in2);
        chk({tag, ".rs2"},     bus.out_rs2, e.rs2);
        chk({tag, ".pc"},      bus.out_pc, e.pc);
        chk({tag, ".illegal"}, 64'(bus.out_illegal), 64'(e.ill));
    endtask

    // Reference decode written from the instruction-format rules.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [63:0] d1,
                                        input logic [63:0] d2, input logic [63:0] pc);
        exp_t r;
        logic signed [11:0] imm;
        longint sv;
        logic [6:0] opc;
        logic [2:0] f3;
        opc = i[6:0];
        f3  = i[14:12];
        r.instr = i;
        r.pc    = pc;
        r.in1   = (i[19:15] == 5'd0) ? 64'd0 : d1;
        r.rs2   = (i[24:20] == 5'd0) ? 64'd0 : d2;
        r.in2   = 64'd0;
        r.ill   = 1'b0;
        if (opc == 7'h33) begin
            r.in2 = r.rs2;
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                r.in2 = 64'(i[25:20]);
                r.instr[31:25] = i[31:25] & 7'h7E;
                r.ill = (f3 == 3'd1) && (i[31:26] != 6'd0);
            end else begin
                imm = i[31:20];
                sv = imm;
                r.in2 = sv;
                r.instr[31:25] = 7'd0;
            end
        end else if (opc == 7'h03) begin
            imm = i[31:20];
            sv = imm;
            r.in2 = sv;
        end else if (opc == 7'h23) begin
            imm = {i[31:25], i[11:7]};
            sv = imm;
            r.in2 = sv;
            r.instr[14:12] = 3'd0;
            r.instr[31:25] = 7'd0;
        end else if (opc == 7'h63) begin
            r.in2 = r.rs2;
            if (f3 == 3'd0 || f3 == 3'd1) begin
                r.instr[14:12] = 3'd0;
                r.instr[31:25] = 7'h20;
            end else if (f3 == 3'd4 || f3 == 3'd5) begin
                r.instr[14:12] = 3'd2;
            end else if (f3 == 3'd6 || f3 == 3'd7) begin
                r.instr[14:12] = 3'd3;
            end else begin
                r.ill = 1'b1;
            end
        end else begin
            r.ill = 1'b1;
            r.in1 = 64'd0;
            r.in2 = 64'd0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        logic [6:0] opcs[6];
        opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h03;
        opcs[3] = 7'h23; opcs[4] = 7'h63; opcs[5] = 7'h37;
        i = $urandom;
        i[6:0] = opcs[$urandom_range(0, 5)];
        if ($urandom_range(0, 3) == 0) i[31:26] = 6'd0;
        return i;
    endfunction

    task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] pc,
                         input logic [63:0] d1, input logic [63:0] d2);
        in_valid = v;
        in_instr = i;
        in_pc    = pc;
        rs1_data = d1;
        rs2_data = d2;
    endtask

    initial begin
        exp_t e;
        logic [31:0] seen[$];
        logic [31:0] seq[3];
        logic fire_in, fire_out, c_taken;
        int n;

        vecs[0]  = '{"addi",      32'hFFD08293, 64'd10,  64'h55, 32'h01D08293, 64'd10,  64'hFFFF_FFFF_FFFF_FFFD, 64'h55, 1'b0};
        vecs[1]  = '{"srai",      32'h4210D293, 64'd7,   64'h66, 32'h4010D293, 64'd7,   64'd33,                  64'h66, 1'b0};
        vecs[2]  = '{"slli_bad",  32'h42109293, 64'd7,   64'h66, 32'h40109293, 64'd7,   64'd33,                  64'h66, 1'b1};
        vecs[3]  = '{"sd",        32'hFE20BC23, 64'h100, 64'hAB, 32'h00208C23, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 64'hAB, 1'b0};
        vecs[4]  = '{"beq",       32'h00208063, 64'd3,   64'd4,  32'h40208063, 64'd3,   64'd4,                   64'd4,  1'b0};
        vecs[5]  = '{"bltu",      32'h0020E063, 64'd3,   64'd4,  32'h0020B063, 64'd3,   64'd4,                   64'd4,  1'b0};
        vecs[6]  = '{"br_f3_010", 32'h0020A063, 64'd3,   64'd4,  32'h0020A063, 64'd3,   64'd4,                   64'd4,  1'b1};
        vecs[7]  = '{"add_x0",    32'h002001B3, 64'h99,  64'h77, 32'h002001B3, 64'd0,   64'h77,                  64'h77, 1'b0};
        vecs[8]  = '{"lui_other", 32'h123452B7, 64'h11,  64'h22, 32'h123452B7, 64'd0,   64'd0,                   64'h22, 1'b1};
        vecs[9]  = '{"ld",        32'h0100B283, 64'h200, 64'h33, 32'h0100B283, 64'h200, 64'd16,                  64'h33, 1'b0};
        vecs[10] = '{"blt",       32'h0020C063, 64'd5,   64'd6,  32'h0020A063, 64'd5,   64'd6,                   64'd6,  1'b0};

        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset.alu_instr", 64'(bus.alu_instr), 64'd0);
        chk("reset.in1",       bus.alu_in1, 64'd0);
        chk("reset.in2",       bus.alu_in2, 64'd0);
        chk("reset.rs2",       bus.out_rs2, 64'd0);
        chk("reset.pc",        bus.out_pc, 64'd0);
        chk("reset.illegal",   64'(bus.out_illegal), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle.in_ready",  64'(in_ready), 64'd1);
        chk("idle.out_valid", 64'(bus.out_valid), 64'd0);

        // Directed decode table, one instruction at a time.
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, vecs[k].instr, 64'h1000 + 64'(k * 4), vecs[k].d1, vecs[k].d2);
            #1;
            chk({vecs[k].name, ".rs1_addr"}, 64'(rs1_addr), 64'(vecs[k].instr[19:15]));
            chk({vecs[k].name, ".rs2_addr"}, 64'(rs2_addr), 64'(vecs[k].instr[24:20]));
            @(negedge clk);
            in_valid = 1'b0;
            e = '{vecs[k].e_instr, vecs[k].e_in1, vecs[k].e_in2, vecs[k].e_rs2,
                  64'h1000 + 64'(k * 4), vecs[k].e_ill};
            chk_out(vecs[k].name, e);
            @(negedge clk);
        end

        // Backpressure: three back-to-back offers with the ALU stalled.
        seq[0] = 32'h00100093; seq[1] = 32'h00200113; seq[2] = 32'h00300193;
        bus.out_ready = 1'b0;
        drive(1'b1, seq[0], 64'h2000, 64'd0, 64'd0);
        @(negedge clk);
        chk("bp.ready_after_1", 64'(in_ready), 64'd1);
        drive(1'b1, seq[1], 64'h2004, 64'd0, 64'd0);
        @(negedge clk);
        chk("bp.ready_after_2", 64'(in_ready), 64'd0);
        chk("bp.head_is_first", 64'(bus.alu_instr), 64'(seq[0]));
        drive(1'b1, seq[2], 64'h2008, 64'd0, 64'd0);
        @(negedge clk);
        chk("bp.third_waits", 64'(in_ready), 64'd0);
        chk("bp.head_stable", 64'(bus.alu_instr), 64'(seq[0]));
        bus.out_ready = 1'b1;
        c_taken = 1'b0;
        n = 0;
        while (seen.size() < 3 && n < 20) begin
            if (c_taken) in_valid = 1'b0;
            fire_in  = in_valid && in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_out) seen.push_back(bus.alu_instr);
            @(negedge clk);
            if (fire_in) c_taken = 1'b1;
            n++;
        end
        in_valid = 1'b0;
        chk("bp.drain_count", 64'(seen.size()), 64'd3);
        for (int k = 0; k < 3; k++)
            chk("bp.order", (k < seen.size()) ? 64'(seen[k]) : 64'hDEAD, 64'(seq[k]));
        @(negedge clk);
        chk("bp.empty_after", 64'(bus.out_valid), 64'd0);

        // Flush while full, with an offer present: everything discarded.
        bus.out_ready = 1'b0;
        drive(1'b1, seq[0], 64'h3000, 64'd0, 64'd0);
        @(negedge clk);
        drive(1'b1, seq[1], 64'h3004, 64'd0, 64'd0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_full.out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_full.in_ready",  64'(in_ready), 64'd1);
        // Flush with output empty and accept present: accept dropped.
        drive(1'b1, seq[2], 64'h3008, 64'd0, 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_accept.out_valid", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset mid-stream.
        drive(1'b1, 32'h00A08093, 64'h4000, 64'd9, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst.out_valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst.in1",       bus.alu_in1, 64'd0);
        chk("async_rst.in_ready",  64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic against a queue-based model of the two-entry buffer.
        sb.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk("rnd.out_valid", 64'(bus.out_valid), 64'(sb.size() > 0));
            chk("rnd.in_ready",  64'(in_ready), 64'(sb.size() < 2));
            if (sb.size() > 0) chk_out("rnd", sb[0]);
            drive($urandom_range(0, 9) < 6, rand_instr(), {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom});
            flush = ($urandom_range(0, 15) == 0);
            bus.out_ready = $urandom_range(0, 1) == 1;
            e = ref_decode(in_instr, rs1_data, rs2_data, in_pc);
            fire_in  = in_valid && (sb.size() < 2);
            fire_out = (sb.size() > 0) && bus.out_ready;
            @(posedge clk);
            if (flush) begin
                sb.delete();
            end else begin
                if (fire_out) void'(sb.pop_front());
                if (fire_in) sb.push_back(e);
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
